// File: rtl/matrix_op_controller.sv
// Sequencer for the matrix coprocessor: fetches operands A and B from the matrix RAM, launches the ALU,
// waits for it and writes the padding-masked result back.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | waiting for start; op_sel/mat_size latched on accept
//   S_CHECK    | validate latched op (one-hot) and size (2..5)
//   S_REJECT   | illegal request, error raised, no RAM/ALU activity
//   S_RD_A     | address=A_ADDR for RD_LATENCY+1 cycles, capture mat_a
//   S_RD_B     | address=B_ADDR for RD_LATENCY+1 cycles, capture mat_b
//   S_EXEC     | one-cycle alu_start pulse, timeout counter loaded
//   S_WAIT_ALU | wait for alu_done or timeout
//   S_WRITE    | address=R_ADDR, wren=1, masked result on data_out
//   S_DONE     | one-cycle done pulse, busy low
module matrix_op_controller #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 8,
  parameter int A_ADDR      = 0,
  parameter int B_ADDR      = 1,
  parameter int R_ADDR      = 2,
  parameter int RD_LATENCY  = 2,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op_sel,
  input  logic [2:0]        mat_size,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] mat_a,
  output logic [DATA_W-1:0] mat_b,
  output logic [1:0]        alu_op,
  output logic [2:0]        alu_size,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_REJECT, S_RD_A, S_RD_B, S_EXEC, S_WAIT_ALU, S_WRITE, S_DONE
  } state_t;

  localparam int CNT_MAX = (ALU_TIMEOUT > RD_LATENCY) ? ALU_TIMEOUT : RD_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int NBYTES  = DATA_W / 8;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(ALU_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        size_q, size_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mat_a_q, mat_a_d;
  logic [DATA_W-1:0] mat_b_q, mat_b_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              cfg_ok;
  logic [5:0]        n_elems;
  logic [DATA_W-1:0] keep_mask;

  assign cfg_ok  = (op_q inside {3'b001, 3'b010, 3'b100}) && (size_q >= 3'd2) && (size_q <= 3'd5);
  assign n_elems = {3'b000, size_q} * {3'b000, size_q};

  // Element 0 sits in the top byte, so padding is everything below byte N*N.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < int'(n_elems)) keep_mask[DATA_W-1-8*i -: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      size_q  <= size_d;
      err_q   <= err_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    size_d  = size_q;
    err_d   = err_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_sel;
          size_d  = mat_size;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_ok) begin
          cnt_d   = RD_LOAD;
          state_d = S_RD_A;
        end else begin
          err_d   = 1'b1;
          state_d = S_REJECT;
        end
      end
      S_REJECT: state_d = S_DONE;
      S_RD_A: begin
        if (cnt_q == '0) begin
          mat_a_d = mem_q;
          cnt_d   = RD_LOAD;
          state_d = S_RD_B;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD_B: begin
        if (cnt_q == '0) begin
          mat_b_d = mem_q;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EXEC: begin
        cnt_d   = TO_LOAD;
        state_d = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          data_d  = alu_result & keep_mask;
          state_d = S_WRITE;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    address = '0;
    unique case (state_q)
      S_RD_A:  address = ADDR_W'(A_ADDR);
      S_RD_B:  address = ADDR_W'(B_ADDR);
      S_WRITE: address = ADDR_W'(R_ADDR);
      default: address = '0;
    endcase
  end

  // Outputs decode straight from state so a reset drops wren without waiting for an edge.
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign wren      = (state_q == S_WRITE);
  assign alu_start = (state_q == S_EXEC);
  assign error     = err_q;
  assign data_out  = data_q;
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign alu_size  = size_q;
  assign alu_op    = op_q[2] ? 2'b10 : (op_q[1] ? 2'b01 : 2'b00);

endmodule

// File: tb/tb_matrix_op_controller.sv
// Self-checking bench for matrix_op_controller: RAM model with 2-cycle read latency, ALU stub with
// programmable delay, table of directed requests plus timeout and mid-write reset sequences.
module tb_matrix_op_controller;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op_sel;
  logic [2:0]   mat_size;
  logic         busy, done, error, wren, alu_start, alu_done;
  logic [7:0]   address;
  logic [255:0] mem_q, data_out, mat_a, mat_b, alu_result;
  logic [1:0]   alu_op;
  logic [2:0]   alu_size;

  matrix_op_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op_sel(op_sel), .mat_size(mat_size),
    .busy(busy), .done(done), .error(error), .address(address), .wren(wren), .mem_q(mem_q),
    .data_out(data_out), .mat_a(mat_a), .mat_b(mat_b), .alu_op(alu_op), .alu_size(alu_size),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: read data follows the address by two cycles.
  logic [255:0] mem [4];
  logic [7:0]   a1, a2;
  always @(posedge clock) begin
    a1 <= address;
    a2 <= a1;
  end
  assign mem_q = mem[a2[1:0]];

  // ALU stub
  int  alu_delay = 0;
  bit  alu_never = 1'b0;
  int  alu_cnt;

  function automatic logic [255:0] alu_calc(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [7:0]   x, y;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      x = a[255-8*k -: 8];
      y = b[255-8*k -: 8];
      case (op)
        2'b00:   r[255-8*k -: 8] = x + y;
        2'b01:   r[255-8*k -: 8] = x - y;
        default: r[255-8*k -: 8] = x * y;
      endcase
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_done   <= 1'b0;
      alu_cnt    <= 0;
      alu_result <= '0;
    end else if (alu_start) begin
      alu_result <= alu_calc(alu_op, mat_a, mat_b);
      alu_done   <= (alu_delay == 0) && !alu_never;
      alu_cnt    <= alu_delay;
    end else if (!alu_done && !alu_never && alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) alu_done <= 1'b1;
    end
  end

  // Bus monitor
  int           n_wr = 0;
  int           n_st = 0;
  logic [7:0]   wr_addr;
  logic [255:0] wr_data;
  logic [1:0]   st_op;
  logic [2:0]   st_size;
  always @(posedge clock) begin
    if (wren) begin
      n_wr    <= n_wr + 1;
      wr_addr <= address;
      wr_data <= data_out;
    end
    if (alu_start) begin
      n_st    <= n_st + 1;
      st_op   <= alu_op;
      st_size <= alu_size;
    end
  end

  // Byte k = base + step*k for k < cnt, tail byte elsewhere (element 0 in the top byte).
  function automatic logic [255:0] mk(input int base, input int step, input int cnt, input logic [7:0] tail);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[255-8*k -: 8] = (k < cnt) ? 8'(base + step * k) : tail;
    return r;
  endfunction

  task automatic run_req(input logic [2:0] op, input logic [2:0] n, input logic [255:0] a,
                         input logic [255:0] b, input int delay, input bit never, input int mid,
                         output int lat, output logic err, output bit busy_ok, output bit idle_after);
    mem[0] = a;
    mem[1] = b;
    mem[2] = '0;
    alu_delay = delay;
    alu_never = never;
    @(negedge clock);
    start = 1'b1; op_sel = op; mat_size = n;
    @(posedge clock); #1;
    start = 1'b0; op_sel = ~op; mat_size = 3'd7;
    busy_ok = busy;
    lat = 0;
    while (lat < 200) begin
      @(posedge clock); #1;
      lat++;
      start = (lat == mid);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    err = error;
    idle_after = !busy;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    idle_after = idle_after && !busy && !done;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [2:0]   n;
    logic [255:0] a;
    logic [255:0] b;
    int           delay;
    int           mid;
    int           exp_lat;
    logic         exp_err;
    int           exp_wr;
    logic [255:0] exp_w;
    logic [1:0]   exp_op;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int   lat, wr0, st0, pulses;
    logic err;
    bit   bok, idle;

    vecs[0] = '{3'b001, 3'd2, mk(1, 1, 4, 8'h11), mk(5, 1, 4, 8'h22), 0, 10, 10, 1'b0, 1, mk(6, 2, 4, 8'h00), 2'b00};
    vecs[1] = '{3'b010, 3'd4, mk(10, 10, 16, 8'h33), mk(1, 1, 16, 8'h44), 0, -1, 10, 1'b0, 1, mk(9, 9, 16, 8'h00), 2'b01};
    vecs[2] = '{3'b100, 3'd5, mk(1, 1, 25, 8'h55), mk(2, 0, 25, 8'h66), 20, -1, 30, 1'b0, 1, mk(2, 2, 25, 8'h00), 2'b10};
    vecs[3] = '{3'b011, 3'd3, mk(1, 1, 9, 8'h00), mk(1, 1, 9, 8'h00), 0, -1, 2, 1'b1, 0, '0, 2'b00};
    vecs[4] = '{3'b001, 3'd1, mk(1, 1, 1, 8'h00), mk(1, 1, 1, 8'h00), 0, -1, 2, 1'b1, 0, '0, 2'b00};
    vecs[5] = '{3'b100, 3'd2, mk(3, 1, 4, 8'h77), mk(4, 0, 4, 8'h01), 0, -1, 10, 1'b0, 1, mk(12, 4, 4, 8'h00), 2'b10};
    vecs[6] = '{3'b000, 3'd3, mk(1, 1, 9, 8'h00), mk(1, 1, 9, 8'h00), 0, -1, 2, 1'b1, 0, '0, 2'b00};
    vecs[7] = '{3'b010, 3'd6, mk(1, 1, 9, 8'h00), mk(1, 1, 9, 8'h00), 0, -1, 2, 1'b1, 0, '0, 2'b00};
    vecs[8] = '{3'b001, 3'd5, mk(0, 1, 25, 8'h99), mk(100, 1, 25, 8'h01), 3, -1, 13, 1'b0, 1, mk(100, 2, 25, 8'h00), 2'b00};

    reset_n = 1'b0; start = 1'b0; op_sel = '0; mat_size = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    #12;
    chk("reset_ctrl", {busy, done, error, wren, alu_start, alu_op, alu_size, address}, '0);
    chk("reset_data", data_out | mat_a | mat_b, '0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      wr0 = n_wr; st0 = n_st;
      run_req(vecs[i].op, vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].delay, 1'b0, vecs[i].mid,
              lat, err, bok, idle);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_error", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_busy_held", i), bok, 1'b1);
      chk($sformatf("v%0d_idle_after", i), idle, 1'b1);
      chk($sformatf("v%0d_writes", i), n_wr - wr0, vecs[i].exp_wr);
      chk($sformatf("v%0d_alu_starts", i), n_st - st0, vecs[i].exp_wr);
      if (vecs[i].exp_wr == 1) begin
        chk($sformatf("v%0d_wr_addr", i), wr_addr, 8'd2);
        chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].exp_w);
        chk($sformatf("v%0d_alu_op", i), st_op, vecs[i].exp_op);
        chk($sformatf("v%0d_alu_size", i), st_size, vecs[i].n);
      end
    end

    // ALU never answers; a start pulse during the wait must not be queued.
    wr0 = n_wr; st0 = n_st;
    run_req(3'b001, 3'd3, mk(1, 1, 9, 8'h00), mk(1, 1, 9, 8'h00), 0, 1'b1, 30, lat, err, bok, idle);
    chk("timeout_latency", lat, 72);
    chk("timeout_error", err, 1'b1);
    chk("timeout_writes", n_wr - wr0, 0);
    chk("timeout_alu_starts", n_st - st0, 1);
    chk("timeout_idle_after", idle, 1'b1);
    alu_never = 1'b0;

    // Reset asserted in the middle of the WRITE cycle.
    mem[0] = mk(1, 1, 4, 8'h11); mem[1] = mk(5, 1, 4, 8'h22);
    alu_delay = 0;
    wr0 = n_wr;
    @(negedge clock);
    start = 1'b1; op_sel = 3'b001; mat_size = 3'd2;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!wren && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("rst_reached_write", lat, 9);
    reset_n = 1'b0;
    #1;
    chk("rst_ctrl_zero", {busy, done, error, wren, alu_start, alu_op, alu_size, address}, '0);
    chk("rst_data_zero", data_out | mat_a | mat_b, '0);
    @(posedge clock); #1;
    chk("rst_no_write", n_wr - wr0, 0);
    @(negedge clock); reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (done || busy) pulses++;
    end
    chk("rst_stays_idle", pulses, 0);

    wr0 = n_wr;
    run_req(3'b001, 3'd2, mk(1, 1, 4, 8'h11), mk(5, 1, 4, 8'h22), 0, 1'b0, -1, lat, err, bok, idle);
    chk("post_rst_latency", lat, 10);
    chk("post_rst_error", err, 1'b0);
    chk("post_rst_writes", n_wr - wr0, 1);
    chk("post_rst_data", wr_data, mk(6, 2, 4, 8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
